// File: rtl/rca_accumulator.sv
// Frame accumulator that sums valid/ready beats through a ripple-carry adder.
// Define RCA_ACC_SUB_EN to add the InSub port for per-beat subtraction.

module rca #(
    parameter int DATA_WID = 64
) (
    input  logic [DATA_WID-1:0] InputA,
    input  logic [DATA_WID-1:0] InputB,
    input  logic                CarryInput,
    output logic [DATA_WID-1:0] Sum,
    output logic                CarryOutput
);
    logic [DATA_WID:0] carry;

    assign carry[0] = CarryInput;

    for (genvar i = 0; i < DATA_WID; i++) begin : g_fa
        assign Sum[i]       = InputA[i] ^ InputB[i] ^ carry[i];
        assign carry[i + 1] = (InputA[i] & InputB[i]) | (carry[i] & (InputA[i] ^ InputB[i]));
    end

    assign CarryOutput = carry[DATA_WID];
endmodule

module rca_accumulator #(
    parameter int DATA_WID  = 64,
    parameter int COUNT_WID = 8
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 InValid,
    output logic                 InReady,
    input  logic [DATA_WID-1:0]  InData,
    input  logic                 InLast,
`ifdef RCA_ACC_SUB_EN
    input  logic                 InSub,
`endif
    output logic                 OutValid,
    input  logic                 OutReady,
    output logic [DATA_WID-1:0]  OutSum,
    output logic [COUNT_WID-1:0] OutCarryCount,
    output logic [COUNT_WID-1:0] OutBeatCount
);
    typedef enum logic {ACC, HOLD} state_t;

    localparam logic [COUNT_WID-1:0] CNT_ONE = COUNT_WID'(1);

    state_t                state_q;
    logic [DATA_WID-1:0]   acc_q;
    logic [COUNT_WID-1:0]  beat_q, beat_d;
    logic [COUNT_WID-1:0]  carry_q, carry_d;
    logic                  in_ready_q;
    logic                  out_valid_q;

    logic [DATA_WID-1:0]   rca_b;
    logic                  rca_cin;
    logic [DATA_WID-1:0]   rca_sum;
    logic                  rca_cout;
    logic                  accept;

`ifdef RCA_ACC_SUB_EN
    // Two's-complement subtract: invert the operand and inject a carry.
    assign rca_b   = InSub ? ~InData : InData;
    assign rca_cin = InSub;
`else
    assign rca_b   = InData;
    assign rca_cin = 1'b0;
`endif

    rca #(.DATA_WID(DATA_WID)) u_rca (
        .InputA      (acc_q),
        .InputB      (rca_b),
        .CarryInput  (rca_cin),
        .Sum         (rca_sum),
        .CarryOutput (rca_cout)
    );

    assign accept = InValid && in_ready_q;

    // Both counters stick at all-ones rather than wrapping.
    always_comb begin
        beat_d  = (&beat_q) ? beat_q : beat_q + CNT_ONE;
        carry_d = (rca_cout && !(&carry_q)) ? carry_q + CNT_ONE : carry_q;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= ACC;
            acc_q       <= '0;
            beat_q      <= '0;
            carry_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ACC: begin
                    if (accept) begin
                        acc_q   <= rca_sum;
                        beat_q  <= beat_d;
                        carry_q <= carry_d;
                        if (InLast) begin
                            state_q     <= HOLD;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (out_valid_q && OutReady) begin
                        state_q     <= ACC;
                        acc_q       <= '0;
                        beat_q      <= '0;
                        carry_q     <= '0;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ACC;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign InReady       = in_ready_q;
    assign OutValid      = out_valid_q;
    assign OutSum        = acc_q;
    assign OutCarryCount = carry_q;
    assign OutBeatCount  = beat_q;
endmodule

// File: tb/tb_rca_accumulator.sv
// Self-checking bench for rca_accumulator (DATA_WID=8, COUNT_WID=4).
// Directed cases plus randomized frames scored against an integer-sum model.

module tb_rca_accumulator;
    localparam int DW = 8;
    localparam int CW = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          Clock = 1'b0;
    logic          Reset;
    logic          InValid;
    logic          InReady;
    logic [DW-1:0] InData;
    logic          InLast;
    logic          OutValid;
    logic          OutReady;
    logic [DW-1:0] OutSum;
    logic [CW-1:0] OutCarryCount;
    logic [CW-1:0] OutBeatCount;
`ifdef RCA_ACC_SUB_EN
    logic          InSub;
    logic          sub_beat;
`endif

    int checks = 0;
    int errors = 0;

    always #5 Clock = ~Clock;

    rca_accumulator #(.DATA_WID(DW), .COUNT_WID(CW)) dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .InValid       (InValid),
        .InReady       (InReady),
        .InData        (InData),
        .InLast        (InLast),
`ifdef RCA_ACC_SUB_EN
        .InSub         (InSub),
`endif
        .OutValid      (OutValid),
        .OutReady      (OutReady),
        .OutSum        (OutSum),
        .OutCarryCount (OutCarryCount),
        .OutBeatCount  (OutBeatCount)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_result(input string tag, input int sum, input int carries, input int beats);
        chk({tag, "_valid"}, 32'(OutValid), 32'd1);
        chk({tag, "_ready"}, 32'(InReady), 32'd0);
        chk({tag, "_sum"},   32'(OutSum), 32'(sum));
        chk({tag, "_carry"}, 32'(OutCarryCount), 32'(carries));
        chk({tag, "_beats"}, 32'(OutBeatCount), 32'(beats));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, 32'(OutValid), 32'd0);
        chk({tag, "_ready"}, 32'(InReady), 32'd1);
        chk({tag, "_sum"},   32'(OutSum), 32'd0);
        chk({tag, "_carry"}, 32'(OutCarryCount), 32'd0);
        chk({tag, "_beats"}, 32'(OutBeatCount), 32'd0);
    endtask

    // Present one beat for one rising edge; inputs change on the falling edge.
    task automatic send(input logic [DW-1:0] d, input bit last);
        InValid = 1'b1;
        InData  = d;
        InLast  = last;
`ifdef RCA_ACC_SUB_EN
        InSub   = sub_beat;
`endif
        @(negedge Clock);
        InValid = 1'b0;
        InLast  = 1'b0;
        InData  = DW'($urandom);
`ifdef RCA_ACC_SUB_EN
        InSub   = 1'b0;
`endif
    endtask

    task automatic handshake();
        OutReady = 1'b1;
        @(negedge Clock);
        OutReady = 1'b0;
    endtask

    initial begin
        Reset    = 1'b1;
        InValid  = 1'b0;
        InData   = '0;
        InLast   = 1'b0;
        OutReady = 1'b0;
`ifdef RCA_ACC_SUB_EN
        InSub    = 1'b0;
        sub_beat = 1'b0;
`endif
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);
        chk_idle("reset");

        // Three-beat frame with one wrap; downstream already ready.
        OutReady = 1'b1;
        send(8'hF0, 1'b0);
        send(8'h20, 1'b0);
        send(8'h05, 1'b1);
        chk_result("frame3", 'h15, 1, 3);
        @(negedge Clock);
        chk_idle("frame3_clear");
        OutReady = 1'b0;

        // Single beat, result held while downstream stalls; offered beats ignored.
        send(8'hAB, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk_result($sformatf("hold%0d", i), 'hAB, 0, 1);
            InValid = 1'b1;
            InData  = 8'h55;
            InLast  = 1'b1;
            @(negedge Clock);
        end
        InValid = 1'b0;
        InLast  = 1'b0;
        chk_result("hold5", 'hAB, 0, 1);
        handshake();
        chk_idle("hold_clear");

        // Twenty 0xFF beats saturate both counters.
        for (int i = 0; i < 20; i++) send(8'hFF, i == 19);
        chk_result("sat", 'hEC, CNT_MAX, CNT_MAX);
        handshake();
        chk_idle("sat_clear");

        // Reset mid-frame discards the partial sum.
        send(8'h10, 1'b0);
        send(8'h10, 1'b0);
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);
        chk_idle("midreset");
        send(8'h01, 1'b1);
        chk_result("after_reset", 'h01, 0, 1);

        // Reset wins over a simultaneous output handshake.
        OutReady = 1'b1;
        Reset    = 1'b1;
        @(negedge Clock);
        Reset    = 1'b0;
        OutReady = 1'b0;
        chk_idle("hold_reset");

`ifdef RCA_ACC_SUB_EN
        sub_beat = 1'b0;
        send(8'h10, 1'b0);
        sub_beat = 1'b1;
        send(8'h20, 1'b1);
        sub_beat = 1'b0;
        chk_result("sub", 'hF0, 0, 2);
        handshake();
        chk_idle("sub_clear");
`endif

        // Random frames: the model keeps the exact integer total, so the
        // modular sum is total mod 256 and the wrap count is total / 256.
        for (int f = 0; f < 30; f++) begin
            int n;
            int total;
            int stall;
            n     = $urandom_range(1, 20);
            total = 0;
            for (int b = 0; b < n; b++) begin
                logic [DW-1:0] d;
                repeat ($urandom_range(0, 2)) begin
                    InValid = 1'b0;
                    InData  = DW'($urandom);
                    InLast  = 1'($urandom);
                    @(negedge Clock);
                    InLast  = 1'b0;
                end
                d = DW'($urandom);
                total += int'(d);
                send(d, b == n - 1);
            end
            stall = $urandom_range(0, 3);
            for (int s = 0; s <= stall; s++) begin
                chk_result($sformatf("rand%0d_%0d", f, s), total % 256,
                           (total / 256 > CNT_MAX) ? CNT_MAX : total / 256,
                           (n > CNT_MAX) ? CNT_MAX : n);
                if (s < stall) @(negedge Clock);
            end
            handshake();
            chk(($sformatf("rand%0d_clear", f)), 32'(OutValid), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end
endmodule
